// File: rtl/can_tx_arbiter_if.sv
// rtl/can_tx_arbiter_if.sv - host and controller signal bundle for can_tx_arbiter
//
// Purpose: groups the mailbox load/abort port, the per-mailbox status, the
// controller TX handshake and the arbiter status into one interface.
// Modports:
//   slave  - seen by can_tx_arbiter (mailbox/controller inputs, status outputs)
//   master - seen by the host/controller side driving the arbiter
// Signals:
//   mb_wr_en/mb_wr_sel/mb_wr_id/mb_wr_dlc/mb_wr_data  mailbox load port
//   mb_wr_err                                         write-rejected pulse
//   mb_abort                                          per-mailbox cancel
//   mb_pending/mb_done                                per-mailbox status
//   ctl_tx_req/ctl_tx_id/ctl_tx_dlc/ctl_tx_data       frame to controller
//   ctl_tx_busy/ctl_tx_complete                       controller status
//   arb_busy/arb_sel/tx_timeout                       arbiter status
interface can_tx_arbiter_if #(
  parameter int NUM_MB = 4
) ();
  localparam int SELW = $clog2(NUM_MB);

  logic              mb_wr_en;
  logic [SELW-1:0]   mb_wr_sel;
  logic [10:0]       mb_wr_id;
  logic [3:0]        mb_wr_dlc;
  logic [63:0]       mb_wr_data;
  logic              mb_wr_err;
  logic [NUM_MB-1:0] mb_abort;
  logic [NUM_MB-1:0] mb_pending;
  logic [NUM_MB-1:0] mb_done;
  logic              ctl_tx_req;
  logic [10:0]       ctl_tx_id;
  logic [3:0]        ctl_tx_dlc;
  logic [63:0]       ctl_tx_data;
  logic              ctl_tx_busy;
  logic              ctl_tx_complete;
  logic              arb_busy;
  logic [SELW-1:0]   arb_sel;
  logic              tx_timeout;

  modport slave (
    input  mb_wr_en, mb_wr_sel, mb_wr_id, mb_wr_dlc, mb_wr_data, mb_abort,
           ctl_tx_busy, ctl_tx_complete,
    output mb_wr_err, mb_pending, mb_done, ctl_tx_req, ctl_tx_id, ctl_tx_dlc,
           ctl_tx_data, arb_busy, arb_sel, tx_timeout
  );

  modport master (
    output mb_wr_en, mb_wr_sel, mb_wr_id, mb_wr_dlc, mb_wr_data, mb_abort,
           ctl_tx_busy, ctl_tx_complete,
    input  mb_wr_err, mb_pending, mb_done, ctl_tx_req, ctl_tx_id, ctl_tx_dlc,
           ctl_tx_data, arb_busy, arb_sel, tx_timeout
  );
endinterface

// File: rtl/can_tx_arbiter.sv
// rtl/can_tx_arbiter.sv - multi-mailbox CAN transmit scheduler
//
// Purpose: holds NUM_MB transmit mailboxes and hands the pending one with the
// lowest 11-bit identifier (ties: lowest mailbox index) to the CAN frame
// controller over its TX_REQ/TX_COMPLETE handshake, then retires it.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      can_tx_arbiter_if.slave (mailbox load/abort, status, controller TX)
// Parameters:
//   NUM_MB          number of mailboxes (2..8)
//   TIMEOUT_CYCLES  REQ watchdog limit in clk cycles
// Optional feature: define CAN_TX_TIMEOUT_EN to enable the REQ watchdog; when
// undefined REQ waits indefinitely and tx_timeout is tied low.
module can_tx_arbiter #(
  parameter int NUM_MB         = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  can_tx_arbiter_if.slave bus
);
  localparam int SELW = $clog2(NUM_MB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_DONE,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [10:0]       r_mb_id   [NUM_MB];
  logic [3:0]        r_mb_dlc  [NUM_MB];
  logic [63:0]       r_mb_data [NUM_MB];
  logic [NUM_MB-1:0] r_pending;
  logic [NUM_MB-1:0] r_done;
  logic              r_wr_err;
  logic              r_req;
  logic [SELW-1:0]   r_sel;
  logic [10:0]       r_tx_id;
  logic [3:0]        r_tx_dlc;
  logic [63:0]       r_tx_data;

  logic [NUM_MB-1:0] w_wr_hit;
  logic [NUM_MB-1:0] w_sel_oh;
  logic [NUM_MB-1:0] w_inflight;
  logic [NUM_MB-1:0] w_abort_ok;
  logic [NUM_MB-1:0] w_cand;
  logic              w_wr_sel_ok;
  logic              w_wr_accept;
  logic              w_found;
  logic [SELW-1:0]   w_best;
  logic [10:0]       w_best_id;
  logic [3:0]        w_best_dlc;
  logic [63:0]       w_best_data;
  logic              w_retire;
  logic              w_expire;
  logic              w_req_nxt;
  logic              w_load;
  logic              w_unused_busy;

  // TX_BUSY carries no sequencing meaning here; the frame retires on TX_COMPLETE.
  assign w_unused_busy = bus.ctl_tx_busy;

  // Mailbox decode. The in-flight mailbox is the one latched by SELECT for the
  // whole of REQ, including the setup cycle before ctl_tx_req rises.
  always_comb begin
    w_wr_hit   = '0;
    w_sel_oh   = '0;
    w_inflight = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      w_wr_hit[i]   = (int'(bus.mb_wr_sel) == i);
      w_sel_oh[i]   = (int'(r_sel) == i);
      w_inflight[i] = (r_state == S_REQ) && (int'(r_sel) == i);
    end
  end

  assign w_wr_sel_ok = (int'(bus.mb_wr_sel) < NUM_MB);
  assign w_wr_accept = bus.mb_wr_en && w_wr_sel_ok &&
                       !(|(w_wr_hit & (r_pending | w_inflight)));
  assign w_abort_ok  = bus.mb_abort & r_pending & ~w_inflight;
  // Mailboxes aborted in the SELECT cycle are not eligible for that selection.
  assign w_cand      = r_pending & ~w_abort_ok;

  // Minimum-ID search; strict less-than keeps the lowest index on equal IDs.
  always_comb begin
    w_found     = 1'b0;
    w_best      = '0;
    w_best_id   = '0;
    w_best_dlc  = '0;
    w_best_data = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (w_cand[i] && (!w_found || (r_mb_id[i] < w_best_id))) begin
        w_found     = 1'b1;
        w_best      = i[SELW-1:0];
        w_best_id   = r_mb_id[i];
        w_best_dlc  = r_mb_dlc[i];
        w_best_data = r_mb_data[i];
      end
    end
  end

  // Completion only counts once the request is actually on the wire.
  assign w_retire = (r_state == S_REQ) && r_req && bus.ctl_tx_complete;

  // Next-state and registered-output intent. The first REQ cycle is a setup
  // cycle: ctl_tx_* are already stable when ctl_tx_req rises a cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_retire) begin
          w_state_nxt = S_DONE;
        end else if (w_expire) begin
          w_state_nxt = S_GAP;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Mailbox storage and pending bits. An accepted write always targets a
  // non-pending, not-in-flight mailbox, so it never collides with a retire;
  // it does take priority over an abort of the same mailbox.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_MB; i++) begin
        r_mb_id[i]   <= '0;
        r_mb_dlc[i]  <= '0;
        r_mb_data[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (w_wr_accept && w_wr_hit[i]) begin
          r_mb_id[i]   <= bus.mb_wr_id;
          r_mb_dlc[i]  <= (bus.mb_wr_dlc > 4'd8) ? 4'd8 : bus.mb_wr_dlc;
          r_mb_data[i] <= bus.mb_wr_data;
          r_pending[i] <= 1'b1;
        end else if (w_abort_ok[i] || (w_retire && w_sel_oh[i])) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Controller-facing registers; ctl_tx_* change only in SELECT, so they hold
  // steady from the setup cycle until the frame retires or times out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_err  <= 1'b0;
      r_done    <= '0;
      r_req     <= 1'b0;
      r_sel     <= '0;
      r_tx_id   <= '0;
      r_tx_dlc  <= '0;
      r_tx_data <= '0;
    end else begin
      r_wr_err <= bus.mb_wr_en && !w_wr_accept;
      r_done   <= w_retire ? w_sel_oh : '0;
      r_req    <= w_req_nxt;
      if (w_load) begin
        r_sel     <= w_best;
        r_tx_id   <= w_best_id;
        r_tx_dlc  <= w_best_dlc;
        r_tx_data <= w_best_data;
      end
    end
  end

`ifdef CAN_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  // Counts cycles with ctl_tx_req high; a completion in the expiry cycle wins.
  assign w_expire = (r_state == S_REQ) && r_req && !bus.ctl_tx_complete &&
                    (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if ((r_state == S_REQ) && r_req && !w_expire) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign bus.tx_timeout = r_timeout;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_expire         = 1'b0;
  assign bus.tx_timeout   = 1'b0;
`endif

  assign bus.mb_wr_err   = r_wr_err;
  assign bus.mb_pending  = r_pending;
  assign bus.mb_done     = r_done;
  assign bus.ctl_tx_req  = r_req;
  assign bus.ctl_tx_id   = r_tx_id;
  assign bus.ctl_tx_dlc  = r_tx_dlc;
  assign bus.ctl_tx_data = r_tx_data;
  assign bus.arb_busy    = r_req;
  assign bus.arb_sel     = r_sel;
endmodule

// File: tb/tb_can_tx_arbiter.sv
// tb/tb_can_tx_arbiter.sv - randomized self-checking bench for can_tx_arbiter
module tb_can_tx_arbiter;
  localparam int NUM_MB         = 6;
  localparam int SELW           = $clog2(NUM_MB);
  localparam int TIMEOUT_CYCLES = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  can_tx_arbiter_if #(.NUM_MB(NUM_MB)) bus ();

  can_tx_arbiter #(
    .NUM_MB         (NUM_MB),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int          vectors;
  int          miscompares;
  int          m_id   [NUM_MB];
  int          m_dlc  [NUM_MB];
  logic [63:0] m_data [NUM_MB];
  bit          m_pend [NUM_MB];
  int          m_infl;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_MB; i++) begin
      m_id[i]   = 0;
      m_dlc[i]  = 0;
      m_data[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_infl = -1;
  endtask

  function automatic logic [63:0] pend_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NUM_MB; i++) if (m_pend[i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit model_any();
    return pend_vec() != 64'd0;
  endfunction

  // CAN priority: smallest identifier wins, then smallest mailbox number.
  // Encoded as one sort key so the winner is simply the minimum key.
  function automatic int model_next();
    int best_key;
    best_key = -1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (m_pend[i] && (best_key < 0 || (m_id[i] * 16 + i) < best_key)) best_key = m_id[i] * 16 + i;
    end
    return (best_key < 0) ? -1 : (best_key % 16);
  endfunction

  task automatic do_write(input int sel, input int id, input int dlc, input logic [63:0] data);
    bit exp_err;
    if (sel >= NUM_MB) exp_err = 1'b1;
    else exp_err = m_pend[sel] || (sel == m_infl);
    bus.mb_wr_en   = 1'b1;
    bus.mb_wr_sel  = SELW'(sel);
    bus.mb_wr_id   = 11'(id);
    bus.mb_wr_dlc  = 4'(dlc);
    bus.mb_wr_data = data;
    tick();
    bus.mb_wr_en = 1'b0;
    chk("wr_err", 64'(bus.mb_wr_err), 64'(exp_err));
    if (!exp_err) begin
      m_pend[sel] = 1'b1;
      m_id[sel]   = id;
      m_dlc[sel]  = (dlc > 8) ? 8 : dlc;
      m_data[sel] = data;
    end
    chk("pending_after_wr", 64'(bus.mb_pending), pend_vec());
  endtask

  task automatic do_abort(input int mask);
    bus.mb_abort = NUM_MB'(mask);
    tick();
    bus.mb_abort = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mask[i] && m_pend[i] && i != m_infl) m_pend[i] = 1'b0;
    end
    chk("pending_after_abort", 64'(bus.mb_pending), pend_vec());
    chk("no_done_on_abort", 64'(bus.mb_done), 64'd0);
  endtask

  task automatic await_frame(output int waited);
    int exp;
    exp    = model_next();
    waited = 0;
    while (bus.ctl_tx_req !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    chk("req_rise", 64'(bus.ctl_tx_req), 64'd1);
    if (bus.ctl_tx_req === 1'b1 && exp >= 0) begin
      m_infl          = exp;
      bus.ctl_tx_busy = 1'b1;
      chk("tx_id", 64'(bus.ctl_tx_id), 64'(m_id[exp]));
      chk("tx_dlc", 64'(bus.ctl_tx_dlc), 64'(m_dlc[exp]));
      chk("tx_data", bus.ctl_tx_data, m_data[exp]);
      chk("arb_sel", 64'(bus.arb_sel), 64'(exp));
      chk("arb_busy", 64'(bus.arb_busy), 64'd1);
    end
  endtask

  task automatic finish_frame(input int hold);
    if (m_infl < 0) return;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("req_held", 64'(bus.ctl_tx_req), 64'd1);
      chk("id_stable", 64'(bus.ctl_tx_id), 64'(m_id[m_infl]));
    end
    bus.ctl_tx_complete = 1'b1;
    tick();
    bus.ctl_tx_complete = 1'b0;
    bus.ctl_tx_busy     = 1'b0;
    m_pend[m_infl] = 1'b0;
    chk("mb_done", 64'(bus.mb_done), 64'(1) << m_infl);
    chk("req_drop", 64'(bus.ctl_tx_req), 64'd0);
    chk("pending_after_done", 64'(bus.mb_pending), pend_vec());
    m_infl = -1;
    tick();
    chk("done_one_cycle", 64'(bus.mb_done), 64'd0);
    chk("req_gap", 64'(bus.ctl_tx_req), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    int order [3];
    bit saw_to;
    vectors     = 0;
    miscompares = 0;
    bus.mb_wr_en        = 1'b0;
    bus.mb_wr_sel       = '0;
    bus.mb_wr_id        = '0;
    bus.mb_wr_dlc       = '0;
    bus.mb_wr_data      = '0;
    bus.mb_abort        = '0;
    bus.ctl_tx_busy     = 1'b0;
    bus.ctl_tx_complete = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 64'(bus.ctl_tx_req), 64'd0);
    chk("rst_id", 64'(bus.ctl_tx_id), 64'd0);
    chk("rst_dlc", 64'(bus.ctl_tx_dlc), 64'd0);
    chk("rst_data", bus.ctl_tx_data, 64'd0);
    chk("rst_pending", 64'(bus.mb_pending), 64'd0);
    chk("rst_done", 64'(bus.mb_done), 64'd0);
    chk("rst_wr_err", 64'(bus.mb_wr_err), 64'd0);
    chk("rst_busy", 64'(bus.arb_busy), 64'd0);
    chk("rst_sel", 64'(bus.arb_sel), 64'd0);
    chk("rst_timeout", 64'(bus.tx_timeout), 64'd0);
    rst_n = 1'b1;
    tick();

    // single frame, fixed latency
    do_write(0, 'h150, 6, 64'h0000_0501_1018_3255);
    await_frame(lat);
    chk("latency", 64'(lat), 64'd3);
    finish_frame(2);

    // three loads in one idle window go out in ID order
    order = '{'h050, 'h150, 'h300};
    do_write(0, 'h300, 2, {$urandom, $urandom});
    do_write(1, 'h050, 3, {$urandom, $urandom});
    do_write(2, 'h150, 4, {$urandom, $urandom});
    for (int k = 0; k < 3; k++) begin
      await_frame(lat);
      chk("order", 64'(bus.ctl_tx_id), 64'(order[k]));
      finish_frame(1);
    end

    // equal IDs: lower mailbox index first
    do_write(3, 'h123, 1, {$urandom, $urandom});
    do_write(1, 'h123, 1, {$urandom, $urandom});
    await_frame(lat);
    chk("tie_first", 64'(bus.arb_sel), 64'd1);
    finish_frame(0);
    await_frame(lat);
    chk("tie_second", 64'(bus.arb_sel), 64'd3);
    finish_frame(0);

    // write/abort the in-flight mailbox, abort a pending one
    do_write(0, 'h200, 8, {$urandom, $urandom});
    do_write(2, 'h400, 8, {$urandom, $urandom});
    await_frame(lat);
    do_write(0, 'h001, 1, 64'h11);
    do_abort(1 << 0);
    do_abort(1 << 2);
    finish_frame(1);
    chk("nothing_left", 64'(bus.mb_pending), 64'd0);

    // DLC clamp and out-of-range mailbox index
    do_write(2, 'h0AA, 15, {$urandom, $urandom});
    do_write(NUM_MB, 'h001, 2, 64'h22);
    await_frame(lat);
    chk("dlc_clamp", 64'(bus.ctl_tx_dlc), 64'd8);
    finish_frame(0);

    // write and abort of the same idle mailbox in one cycle: write wins
    bus.mb_abort = NUM_MB'(1 << 4);
    do_write(4, 'h321, 5, {$urandom, $urandom});
    bus.mb_abort = '0;
    await_frame(lat);
    finish_frame(0);

    // controller never completes
    do_write(5, 'h7FF, 8, {$urandom, $urandom});
    await_frame(lat);
`ifdef CAN_TX_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      tick();
      chk("wd_req_high", 64'(bus.ctl_tx_req), 64'd1);
      chk("wd_no_pulse", 64'(bus.tx_timeout), 64'd0);
    end
    tick();
    chk("wd_req_drop", 64'(bus.ctl_tx_req), 64'd0);
    chk("wd_pulse", 64'(bus.tx_timeout), 64'd1);
    chk("wd_no_done", 64'(bus.mb_done), 64'd0);
    m_infl = -1;
    chk("wd_still_pending", 64'(bus.mb_pending), pend_vec());
    tick();
    chk("wd_pulse_end", 64'(bus.tx_timeout), 64'd0);
    await_frame(lat);
    finish_frame(0);
`else
    saw_to = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.tx_timeout !== 1'b0) saw_to = 1'b1;
    end
    chk("no_wd_req_high", 64'(bus.ctl_tx_req), 64'd1);
    chk("no_wd_pulse", 64'(saw_to), 64'd0);
    finish_frame(0);
`endif

    // randomized rounds: one frame in flight while others load/abort
    for (int r = 0; r < 12; r++) begin
      int x;
      int n;
      x = $urandom_range(0, NUM_MB - 1);
      do_write(x, $urandom_range(0, 2047), $urandom_range(0, 15), {$urandom, $urandom});
      await_frame(lat);
      chk("rnd_latency", 64'(lat), 64'd3);
      for (int j = 0; j < 4; j++) begin
        do_write($urandom_range(0, 7), $urandom_range(0, 2047), $urandom_range(0, 15),
                 {$urandom, $urandom});
      end
      do_abort($urandom_range(0, (1 << NUM_MB) - 1));
      finish_frame($urandom_range(0, 3));
      n = 0;
      while (model_any() && n < NUM_MB) begin
        await_frame(lat);
        finish_frame($urandom_range(0, 3));
        n++;
      end
    end

    // reset during a frame drops the request at once, no completion
    do_write(1, 'h0F0, 4, {$urandom, $urandom});
    await_frame(lat);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus.ctl_tx_req), 64'd0);
    chk("mid_rst_pending", 64'(bus.mb_pending), 64'd0);
    chk("mid_rst_busy", 64'(bus.arb_busy), 64'd0);
    chk("mid_rst_id", 64'(bus.ctl_tx_id), 64'd0);
    bus.ctl_tx_busy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 64'(bus.mb_done), 64'd0);
    do_write(3, 'h010, 2, {$urandom, $urandom});
    await_frame(lat);
    chk("post_rst_latency", 64'(lat), 64'd3);
    finish_frame(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
